// File: rtl/scale_pow2_ctrl.sv
// scale_pow2_ctrl
//   Sequential power-of-two scaler for a signed Q6.2 operand. On an accepted
//   start it multiplies or divides the operand by 2 once per clock, for
//   `count` steps. A multiply step whose result would not fit is an overflow.
//   In that case the remaining steps are abandoned and the last good value is
//   reported.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   begin an operation (honoured only while idle)
//   a        in   [7:0] signed Q6.2 operand
//   op_mul2  in   1 = x2 per step, 0 = /2 per step (truncate toward zero)
//   count    in   [CNT_W-1:0] number of steps
//   busy     out  high from the capture edge until the done cycle ends
//   done     out  one-cycle completion pulse
//   result   out  [7:0] signed Q6.2 result, held until the next completion
//   err      out  overflow flag of the last completed operation
module scale_pow2_ctrl #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       a,
  input  logic             op_mul2,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [7:0]       result,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic signed [7:0] acc;
  logic              op_r;
  logic [CNT_W-1:0]  rem;

  // One step of the datapath, evaluated combinationally from acc.
  logic              mul_ovf;
  logic signed [7:0] mul_val;
  logic signed [7:0] acc_adj;
  logic signed [7:0] div_val;
  logic signed [7:0] step_val;
  logic              step_ovf;
  logic              last_step;

  // Magnitude above 63 cannot double into 8 bits. -64 is also rejected:
  // its double (-128) fits, but only magnitudes up to 63 count as safe.
  assign mul_ovf  = (acc > 8'sd63) || (acc < -8'sd63);
  assign mul_val  = acc <<< 1;

  // An arithmetic shift rounds toward -inf. Biasing negative values by +1
  // first turns that into truncation toward zero (-7 -> -3, -128 -> -64).
  assign acc_adj  = acc + (acc[7] ? 8'sd1 : 8'sd0);
  assign div_val  = acc_adj >>> 1;

  assign step_val  = op_r ? mul_val : div_val;
  assign step_ovf  = op_r & mul_ovf;
  assign last_step = (rem == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      op_r   <= 1'b0;
      rem    <= '0;
      result <= 8'h00;
      err    <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            acc  <= a;
            op_r <= op_mul2;
            rem  <= count;
            err  <= 1'b0;
            busy <= 1'b1;
            if (count == '0) begin
              // Nothing to do: report the operand straight away.
              result <= a;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          busy <= 1'b1;
          if (step_ovf) begin
            // Keep acc as it was and report the last value that fit.
            err    <= 1'b1;
            result <= acc;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            acc <= step_val;
            rem <= rem - CNT_W'(1);
            if (last_step) begin
              result <= step_val;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end

        DONE: begin
          // start is ignored here; the next request is taken in IDLE.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scale_pow2_ctrl.sv
// Testbench for scale_pow2_ctrl. The reference model precomputes the outcome
// of each accepted operation: the final value, the error flag and the number
// of step edges. It then counts those edges down. The DUT outputs are compared
// with the model every cycle.
module tb_scale_pow2_ctrl;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [7:0]       a = '0;
  logic             op_mul2 = 1'b0;
  logic [CNT_W-1:0] count = '0;
  logic             busy, done, err;
  logic [7:0]       result;

  scale_pow2_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .op_mul2(op_mul2),
    .count(count), .busy(busy), .done(done), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Outcome of one operation from plain integer arithmetic.
  // k = number of step edges before done (0 for count=0).
  function automatic void model_op(input logic [7:0] av, input logic m, input int n,
                                   output logic [7:0] r, output logic e, output int k);
    int v;
    bit stop;
    v = int'($signed(av));
    e = 1'b0;
    k = n;
    stop = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!stop) begin
        if (m) begin
          if (v > 63 || v < -63) begin
            e = 1'b1;
            k = i + 1;
            stop = 1'b1;
          end else begin
            v = v * 2;
          end
        end else begin
          v = v / 2;
        end
      end
    end
    r = v[7:0];
  endfunction

  // Cycle-level model driven by the same sampled inputs as the DUT.
  logic       m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [7:0] m_res = '0;
  logic [7:0] p_res;
  logic       p_err;
  int         p_k;
  int         left = 0;
  bit         m_live = 1'b0;

  always @(posedge clk) begin
    m_live = 1'b1;
    if (rst) begin
      m_busy = 0; m_done = 0; m_err = 0; m_res = 8'h00; left = 0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (m_busy) begin
      left--;
      if (left == 0) begin
        m_done = 1; m_res = p_res; m_err = p_err;
      end
    end else if (start) begin
      model_op(a, op_mul2, int'(count), p_res, p_err, p_k);
      m_busy = 1;
      m_err  = 0;
      if (p_k == 0) begin
        m_done = 1; m_res = p_res; m_err = p_err;
      end else begin
        left = p_k;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("busy",   32'(busy),   32'(m_busy));
      chk("done",   32'(done),   32'(m_done));
      chk("result", 32'(result), 32'(m_res));
      chk("err",    32'(err),    32'(m_err));
    end
  end

  // Directed operation: accept at E0, then measure the cycles until done.
  task automatic run_op(input logic [7:0] av, input logic m, input logic [CNT_W-1:0] n,
                        input logic [7:0] er, input logic ee, input int ek, input string nm);
    int c;
    @(posedge clk); #2;
    start = 1; a = av; op_mul2 = m; count = n;
    @(posedge clk); #2;            // just after E0
    start = 0; a = $urandom; op_mul2 = $urandom; count = $urandom;
    c = 0;
    while (done !== 1'b1 && c < 40) begin
      @(posedge clk); #2;
      c++;
    end
    chk({nm, "_latency"}, 32'(c), 32'(ek));
    chk({nm, "_result"},  32'(result), 32'(er));
    chk({nm, "_err"},     32'(err), 32'(ee));
    @(posedge clk); #2;            // back in IDLE
  endtask

  initial begin
    logic [7:0] r;
    logic       e;
    int         k, ndone;

    // Hand-computed outcomes that pin the model function itself.
    model_op(8'h05, 1'b1, 3, r, e, k);
    chk("model_mul_r", 32'(r), 32'h28); chk("model_mul_k", 32'(k), 3);
    model_op(8'h30, 1'b1, 3, r, e, k);
    chk("model_ovf_r", 32'(r), 32'h60); chk("model_ovf_e", 32'(e), 1); chk("model_ovf_k", 32'(k), 2);
    model_op(8'hF9, 1'b0, 2, r, e, k);
    chk("model_div_r", 32'(r), 32'hFF);
    model_op(8'h80, 1'b0, 1, r, e, k);
    chk("model_m128_r", 32'(r), 32'hC0);

    repeat (2) @(posedge clk);
    #2 rst = 0;
    chk("rst_busy", 32'(busy), 0); chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0); chk("rst_err", 32'(err), 0);

    run_op(8'h05, 1'b1, 3'd3, 8'h28, 1'b0, 3, "mul3");
    run_op(8'h30, 1'b1, 3'd3, 8'h60, 1'b1, 2, "ovf");
    run_op(8'hF9, 1'b0, 3'd2, 8'hFF, 1'b0, 2, "div_neg");
    run_op(8'h80, 1'b0, 3'd1, 8'hC0, 1'b0, 1, "div_m128");
    run_op(8'h9C, 1'b1, 3'd0, 8'h9C, 1'b0, 0, "cnt0");
    run_op(8'hC0, 1'b1, 3'd1, 8'hC0, 1'b1, 1, "ovf_m64");
    run_op(8'h07, 1'b0, 3'd1, 8'h03, 1'b0, 1, "div_pos");

    // start held high across RUN/DONE: back-to-back accepts, one done each.
    @(posedge clk); #2;
    start = 1; a = 8'h01; op_mul2 = 1; count = 3'd2;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      if (done) ndone++;
    end
    start = 0;
    // Each op: E0, 2 steps, done cycle, then IDLE re-accepts -> 4 cycles per op.
    chk("held_start_dones", 32'(ndone), 3);
    repeat (6) @(posedge clk);

    // Reset mid-RUN aborts with no done pulse.
    #2 start = 1; a = 8'h01; op_mul2 = 1; count = 3'd5;
    @(posedge clk); #2 start = 0;
    @(posedge clk); #2 rst = 1;
    @(posedge clk); #2 rst = 0;
    chk("abort_busy", 32'(busy), 0); chk("abort_done", 32'(done), 0);
    chk("abort_result", 32'(result), 0); chk("abort_err", 32'(err), 0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 0);

    // Randomized traffic with occasional resets; checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      start   = ($urandom_range(2, 0) == 0);
      a       = $urandom;
      op_mul2 = $urandom;
      count   = $urandom;
      rst     = ($urandom_range(60, 0) == 0);
    end
    rst = 0; start = 0;
    repeat (12) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scale_pow2_ctrl.md
SCALE_POW2_CTRL -- requirements
Module: scale_pow2_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 3, width of the step-count input.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a scaling operation.
REQ-005 SHALL have port a  input  8  signed Q6.2 operand.
REQ-006 SHALL have port op_mul2  input  1  direction: 1 = multiply by 2 per step, 0 = divide by 2 per step.
REQ-007 SHALL have port count  input  CNT_W  number of steps N (operation computes a*2^N or a/2^N).
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  single-cycle completion pulse.
REQ-010 SHALL have port result  output  8  signed Q6.2 result.
REQ-011 SHALL have port err  output  1  overflow flag of the last completed operation.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE, all registered.
REQ-013 SHALL, in IDLE with start=1, capture a into accumulator acc, op_mul2 into op_r and count into rem at that edge (E0), and clear err.
REQ-014 SHALL, at E0, go to RUN if count>0, otherwise go directly to DONE with result=a.
REQ-015 SHALL, in RUN, apply exactly one step to acc per clock and decrement rem by 1.
REQ-016 SHALL define the mul2 step: |acc|<=63 gives acc*2; |acc|>63, with -128 counted as magnitude 128, is overflow.
REQ-017 SHALL define the div2 step: truncation toward zero (-7 -> -3, 7 -> 3), with -128 -> -64 and no error possible.
REQ-018 SHALL, on mul2 overflow at edge Ek, leave acc unchanged, set err=1, load result=acc (the pre-overflow value) and go to DONE, abandoning the remaining steps.
REQ-019 SHALL, on the step that brings rem to 0, load result with the new acc value and go to DONE.
REQ-020 SHALL hold done=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-021 SHALL give a latency where, for a non-overflowing operation, done is high in the cycle following edge E0+count (count=0: the cycle following E0).
REQ-022 SHALL drive busy=1 in RUN and DONE, and busy=0 in IDLE.
REQ-023 SHALL ignore start while busy=1, including start in the DONE cycle; inputs a, op_mul2 and count are don't-care outside the capture edge.
REQ-024 SHALL hold result and err stable from the DONE cycle until the next DONE; err is cleared only at the next capture edge.
REQ-025 SHALL never write acc or result with a wrapped (modulo-256) product.

Reset
REQ-026 SHALL, when rst=1 at a rising edge, force state=IDLE, acc=0, rem=0, result=8'h00, err=0, done=0 and busy=0, regardless of state.
REQ-027 SHALL treat rst as dominant over start on the same edge; an interrupted operation produces no done pulse.

Verification
REQ-028 SHALL cover: a=8'h05 (1.25), op_mul2=1, count=3 -> done in the cycle after E3, result=8'h28 (10.0), err=0.
REQ-029 SHALL cover: a=8'h30 (12.0), op_mul2=1, count=3 -> step 1 gives 8'h60; step 2 overflows; done in the cycle after E2, result=8'h60, err=1.
REQ-030 SHALL cover: a=8'hF9 (-1.75), op_mul2=0, count=2 -> result=8'hFF, err=0; separately a=8'h80, op_mul2=0, count=1 -> result=8'hC0.
REQ-031 SHALL cover: count=0, a=8'h9C -> done in the cycle after E0, result=8'h9C, busy high for exactly 1 cycle.
REQ-032 SHALL cover: start re-asserted during RUN and DONE -> ignored, with a single done per accepted start; a new start in the first IDLE cycle after DONE is accepted.
REQ-033 SHALL cover: rst asserted mid-RUN -> next cycle busy=0, done=0, result=8'h00, err=0; no done pulse from the aborted operation.
